fsm1011_moore_overlap: RTL and testbench

Moore-type serial sequence detector for the bit pattern 1011, with overlapping matches allowed. It samples one input bit per clock and asserts its output for exactly one cycle after each complete match. It is a standalone leaf block used as a pattern-detect primitive in serial datapaths.

---
 rtl/fsm1011_moore_overlap.sv | 60 ++++++
 tb/tb_fsm1011_moore_overlap.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fsm1011_moore_overlap.sv
// -----------------------------------------------------------------------------
// fsm1011_moore_overlap
//
// Moore serial detector for the bit pattern 1011. Overlapping matches are
// allowed. One bit is sampled per rising clock edge. The detect flag is high
// for the one cycle in which the FSM sits in the "1011 seen" state.
//
// Ports:
//   clk  - system clock; all state updates occur on the rising edge
//   rst  - asynchronous, active-low reset (0 = reset asserted)
//   in   - serial data bit, sampled on each rising clk edge
//   out  - detect flag; 1 only while PS == S4
// -----------------------------------------------------------------------------
module fsm1011_moore_overlap (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  typedef enum logic [2:0] {
    S0 = 3'b000,  // idle / no useful prefix
    S1 = 3'b001,  // saw "1"
    S2 = 3'b010,  // saw "10"
    S3 = 3'b011,  // saw "101"
    S4 = 3'b100   // saw "1011"
  } state_e;

  // Kept as a plain vector so the unused codes 101..111 are representable
  // and can be decoded back to S0.
  logic [2:0] PS;
  logic [2:0] NS;

  // Next-state logic
  always_comb begin
    NS = S0;
    case (PS)
      S0:      NS = in ? S1 : S0;
      S1:      NS = in ? S1 : S2;
      S2:      NS = in ? S3 : S0;
      S3:      NS = in ? S4 : S2;
      // Trailing "1" or "10" of the match is reused as the next prefix.
      S4:      NS = in ? S1 : S2;
      default: NS = S0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PS <= S0;
    end else begin
      PS <= NS;
    end
  end

  // Moore output: decoded from the state register only, never from in.
  assign out = (PS == S4);

endmodule

// File: tb/tb_fsm1011_moore_overlap.sv
// -----------------------------------------------------------------------------
// tb_fsm1011_moore_overlap
//
// Self-checking bench for fsm1011_moore_overlap. Stimulus is driven on the
// falling edge; the expected state/flag for the following rising edge is
// pushed to a queue and popped and compared 1 time unit after that edge.
// The expected flag comes from a 4-bit history of sampled bits since the
// last reset (overlapping 1011 means "last four bits are 1011").
// -----------------------------------------------------------------------------
module tb_fsm1011_moore_overlap;

  logic clk;
  logic rst;
  logic in;
  logic out;

  fsm1011_moore_overlap dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       chk_ps;
    logic [2:0] ps;
    logic       out;
  } exp_t;

  exp_t       q[$];
  logic [3:0] hist;
  int         n_pass;
  int         n_total;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one bit on the falling edge and queue what the next rising edge
  // must produce.
  task automatic send(input logic b, input logic chk, input logic [2:0] ps);
    exp_t e;
    @(negedge clk);
    in = b;
    if (!rst) begin
      hist = '0;
      e.chk_ps = 1'b1;
      e.ps     = 3'd0;
      e.out    = 1'b0;
    end else begin
      hist     = {hist[2:0], b};
      e.chk_ps = chk;
      e.ps     = ps;
      e.out    = (hist == 4'b1011);
    end
    q.push_back(e);
  endtask

  // bits: string of '0'/'1'; states: expected PS digit per bit, '-' = skip.
  task automatic seq(input string bits, input string states);
    for (int i = 0; i < bits.len(); i++) begin
      byte s;
      s = (i < states.len()) ? states[i] : 8'h2d;
      send(bits[i] == 8'h31, s != 8'h2d, s[2:0]);
    end
  endtask

  // Scoreboard consumer
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("out", {3'b000, out}, {3'b000, e.out});
        if (e.chk_ps) check("ps", {1'b0, dut.PS}, {1'b0, e.ps});
      end
    end
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    hist    = '0;
    in      = 1'b0;
    rst     = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_ps", {1'b0, dut.PS}, 4'd0);
    check("rst_async_out", {3'b000, out}, 4'd0);

    // 1. Held in reset with in toggling; ends on 0 so the idle edge stays in S0
    seq("01101010", "00000000");
    @(negedge clk);
    rst  = 1'b1;
    hist = '0;

    // 2. Basic match
    seq("01011", "01234");
    // 3. Overlap and retrigger, then drain
    seq("011", "234");
    seq("1011", "1234");
    seq("000", "200");
    // 4. Near-misses
    seq("100111010", "120111232");
    seq("00", "00");
    // 5. Chained overlap
    seq("1011011011", "1234234234");
    seq("00", "20");

    // Asynchronous reset while in S3
    seq("101", "123");
    @(posedge clk);
    #3;
    check("pre_rst_s3", {1'b0, dut.PS}, 4'd3);
    rst = 1'b0;
    #1;
    check("midrst_ps", {1'b0, dut.PS}, 4'd0);
    check("midrst_out", {3'b000, out}, 4'd0);
    @(negedge clk);
    in = 1'b0;
    @(negedge clk);
    check("midrst_hold", {1'b0, dut.PS}, 4'd0);
    rst  = 1'b1;
    hist = '0;

    // 6. Illegal-state recovery
    @(negedge clk);
    force dut.PS = 3'b101;
    #1;
    check("ill5_out", {3'b000, out}, 4'd0);
    release dut.PS;
    @(posedge clk);
    #2;
    check("ill5_rec", {1'b0, dut.PS}, 4'd0);

    @(negedge clk);
    force dut.PS = 3'b110;
    #1;
    check("ill6_out", {3'b000, out}, 4'd0);
    release dut.PS;
    @(posedge clk);
    #2;
    check("ill6_rec", {1'b0, dut.PS}, 4'd0);

    @(negedge clk);
    in = 1'b1;
    force dut.PS = 3'b111;
    #1;
    check("ill7_out", {3'b000, out}, 4'd0);
    release dut.PS;
    @(posedge clk);
    #2;
    check("ill7_rec", {1'b0, dut.PS}, 4'd0);
    hist = '0;

    // Normal detection after recovery
    seq("1011", "1234");
    seq("0", "2");

    @(posedge clk);
    #3;
    check("q_empty", 4'(q.size()), 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
